// File: rtl/bf_scan_scheduler.sv
// Frame-level raster sequencer for the delay-and-sum beamformer core.
// Walks lateral lines (outer) and depth points (inner), issues one core
// request per focal point, and forwards each result on a valid/ready stream.
module bf_scan_scheduler #(
    parameter int COORD_W = 16,
    parameter int OUT_W   = 18,
    parameter int NUM_X   = 4,
    parameter int NUM_Z   = 256,
    parameter int X_START = 0,
    parameter int X_STEP  = 1,
    parameter int Z_START = 0,
    parameter int Z_STEP  = 1,
    parameter int TIMEOUT = 1023,
    localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1,
    localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               frame_done,
    output logic               err_timeout,
    output logic               bf_start,
    output logic [COORD_W-1:0] bf_x_f,
    output logic [COORD_W-1:0] bf_z_f,
    input  logic               bf_valid,
    input  logic [OUT_W-1:0]   bf_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [OUT_W-1:0]   pix_data,
    output logic [XW-1:0]      pix_x_idx,
    output logic [ZW-1:0]      pix_z_idx,
    output logic               pix_last,
    output logic [1:0]         debug_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [XW-1:0]      X_LAST  = XW'(NUM_X - 1);
    localparam logic [ZW-1:0]      Z_LAST  = ZW'(NUM_Z - 1);
    localparam logic [CW-1:0]      CNT_END = CW'(TIMEOUT - 1);
    localparam logic [COORD_W-1:0] X_INIT  = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Z_INIT  = COORD_W'(Z_START);
    localparam logic [COORD_W-1:0] X_INC   = COORD_W'(X_STEP);
    localparam logic [COORD_W-1:0] Z_INC   = COORD_W'(Z_STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, z_q, z_d;
    logic [XW-1:0]      ix_q, ix_d;
    logic [ZW-1:0]      iz_q, iz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OUT_W-1:0]   pix_data_q, pix_data_d;
    logic [XW-1:0]      pix_xi_q, pix_xi_d;
    logic [ZW-1:0]      pix_zi_q, pix_zi_d;
    logic               pix_last_q, pix_last_d;
    logic               pix_valid_q, pix_valid_d;
    logic               bf_start_q, bf_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Next-state and datapath: raster walk, capture, timeout, abort override.
    // Strobe outputs are derived from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        z_d        = z_q;
        ix_d       = ix_q;
        iz_d       = iz_q;
        cnt_d      = '0;
        pix_data_d = pix_data_q;
        pix_xi_d   = pix_xi_q;
        pix_zi_d   = pix_zi_q;
        pix_last_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ix_d    = '0;
                        iz_d    = '0;
                        x_d     = X_INIT;
                        z_d     = Z_INIT;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A result on the final counted cycle still wins over timeout.
                    if (bf_valid) begin
                        pix_data_d = bf_data;
                        pix_xi_d   = ix_q;
                        pix_zi_d   = iz_q;
                        pix_last_d = (ix_q == X_LAST) && (iz_q == Z_LAST);
                        state_d    = S_OUTPUT;
                    end else if (cnt_q == CNT_END) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_OUTPUT: begin
                    pix_last_d = pix_last_q;
                    if (pix_ready) begin
                        pix_last_d = 1'b0;
                        if (pix_last_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            if (iz_q == Z_LAST) begin
                                iz_d = '0;
                                z_d  = Z_INIT;
                                ix_d = ix_q + XW'(1);
                                x_d  = x_q + X_INC;
                            end else begin
                                iz_d = iz_q + ZW'(1);
                                z_d  = z_q + Z_INC;
                            end
                            state_d = S_ISSUE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pix_valid_d = (state_d == S_OUTPUT);
        bf_start_d  = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered outputs; async reset returns everything to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            x_q         <= X_INIT;
            z_q         <= Z_INIT;
            ix_q        <= '0;
            iz_q        <= '0;
            cnt_q       <= '0;
            pix_data_q  <= '0;
            pix_xi_q    <= '0;
            pix_zi_q    <= '0;
            pix_last_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            bf_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            z_q         <= z_d;
            ix_q        <= ix_d;
            iz_q        <= iz_d;
            cnt_q       <= cnt_d;
            pix_data_q  <= pix_data_d;
            pix_xi_q    <= pix_xi_d;
            pix_zi_q    <= pix_zi_d;
            pix_last_q  <= pix_last_d;
            pix_valid_q <= pix_valid_d;
            bf_start_q  <= bf_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign err_timeout = err_q;
    assign bf_start    = bf_start_q;
    assign bf_x_f      = x_q;
    assign bf_z_f      = z_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x_idx   = pix_xi_q;
    assign pix_z_idx   = pix_zi_q;
    assign pix_last    = pix_last_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_bf_scan_scheduler.sv
// Bench for bf_scan_scheduler: a raster scoreboard for a 2x3 configuration,
// plus a separate instance exercising lateral coordinate wrap-around.
module tb_bf_scan_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: NUM_X=2, NUM_Z=3, X 10 step 5, Z 0 step 4, TIMEOUT 8
    logic        a_start, a_abort, a_busy, a_frame_done, a_err_timeout, a_bf_start;
    logic [15:0] a_bf_x_f, a_bf_z_f;
    logic        a_bf_valid;
    logic [17:0] a_bf_data;
    logic        a_pix_valid, a_pix_ready;
    logic [17:0] a_pix_data;
    logic [0:0]  a_pix_x_idx;
    logic [1:0]  a_pix_z_idx;
    logic        a_pix_last;
    logic [1:0]  a_debug_state;

    // Instance B: NUM_X=4, NUM_Z=1, X starts at FFFE
    logic        b_start, b_abort, b_busy, b_frame_done, b_err_timeout, b_bf_start;
    logic [15:0] b_bf_x_f, b_bf_z_f;
    logic        b_bf_valid;
    logic [17:0] b_bf_data;
    logic        b_pix_valid, b_pix_ready;
    logic [17:0] b_pix_data;
    logic [1:0]  b_pix_x_idx;
    logic [0:0]  b_pix_z_idx;
    logic        b_pix_last;
    logic [1:0]  b_debug_state;

    bf_scan_scheduler #(
        .COORD_W(16), .OUT_W(18), .NUM_X(2), .NUM_Z(3),
        .X_START(10), .X_STEP(5), .Z_START(0), .Z_STEP(4), .TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .busy(a_busy), .frame_done(a_frame_done), .err_timeout(a_err_timeout),
        .bf_start(a_bf_start), .bf_x_f(a_bf_x_f), .bf_z_f(a_bf_z_f),
        .bf_valid(a_bf_valid), .bf_data(a_bf_data),
        .pix_valid(a_pix_valid), .pix_ready(a_pix_ready), .pix_data(a_pix_data),
        .pix_x_idx(a_pix_x_idx), .pix_z_idx(a_pix_z_idx), .pix_last(a_pix_last),
        .debug_state(a_debug_state)
    );

    bf_scan_scheduler #(
        .COORD_W(16), .OUT_W(18), .NUM_X(4), .NUM_Z(1),
        .X_START(16'hFFFE), .X_STEP(1), .Z_START(0), .Z_STEP(1), .TIMEOUT(1023)
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .busy(b_busy), .frame_done(b_frame_done), .err_timeout(b_err_timeout),
        .bf_start(b_bf_start), .bf_x_f(b_bf_x_f), .bf_z_f(b_bf_z_f),
        .bf_valid(b_bf_valid), .bf_data(b_bf_data),
        .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_data(b_pix_data),
        .pix_x_idx(b_pix_x_idx), .pix_z_idx(b_pix_z_idx), .pix_last(b_pix_last),
        .debug_state(b_debug_state)
    );

    typedef struct {
        logic [17:0] data;
        int          ix;
        int          iz;
        bit          last;
    } pix_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] z;
    } pt_t;

    pix_t pq[$];
    pt_t  cq[$];
    int   total = 0;
    int   bad   = 0;
    int   bs_cnt = 0;
    bit   done_exp = 1'b0;
    bit   core_en = 1'b1;
    bit   a_late = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Reference raster: every point is computed directly from its indices.
    task automatic push_frame(input int nx, input int nz, input int xs, input int xstep,
                              input int zs, input int zstep);
        pix_t p;
        pt_t  c;
        int   xv, zv;
        for (int i = 0; i < nx; i++) begin
            for (int j = 0; j < nz; j++) begin
                xv = (xs + i * xstep) & 32'hFFFF;
                zv = (zs + j * zstep) & 32'hFFFF;
                c.x = 16'(xv);
                c.z = 16'(zv);
                p.data = 18'(xv * 16 + zv);
                p.ix = i;
                p.iz = j;
                p.last = (i == nx - 1) && (j == nz - 1);
                cq.push_back(c);
                pq.push_back(p);
            end
        end
    endtask

    task automatic flush();
        cq.delete();
        pq.delete();
    endtask

    // Core model for A: 2-cycle latency, data = x*16 + z.
    initial begin
        int cw, cxi, czi;
        cw = 0; cxi = 0; czi = 0;
        a_bf_valid = 1'b0;
        a_bf_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            a_bf_valid = 1'b0;
            if (cw > 0) begin
                cw--;
                if (cw == 0) begin
                    a_bf_valid = 1'b1;
                    a_bf_data  = 18'(cxi * 16 + czi);
                end
            end
            if (a_late) begin
                a_bf_valid = 1'b1;
                a_bf_data  = 18'h3FFFF;
                a_late     = 1'b0;
            end
            if (a_bf_start && core_en && reset) begin
                cw  = 2;
                cxi = int'(a_bf_x_f);
                czi = int'(a_bf_z_f);
            end
        end
    end

    // Core model for B: 1-cycle latency.
    initial begin
        bit pend;
        pend = 1'b0;
        b_bf_valid = 1'b0;
        b_bf_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            b_bf_valid = pend;
            b_bf_data  = {2'b00, b_bf_x_f};
            pend = b_bf_start;
        end
    end

    // Per-cycle scoreboard compare for A.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("frame_done", 32'(a_frame_done), 32'(done_exp));
                done_exp = 1'b0;
                if (a_bf_start) begin
                    bs_cnt++;
                    if (cq.size() == 0) fail_now("bf_start with no point pending");
                    else begin
                        chk("bf_x_f", 32'(a_bf_x_f), 32'(cq[0].x));
                        chk("bf_z_f", 32'(a_bf_z_f), 32'(cq[0].z));
                        void'(cq.pop_front());
                    end
                end
                if (a_pix_valid) begin
                    if (pq.size() == 0) fail_now("pix_valid with no pixel pending");
                    else begin
                        chk("pix_data", 32'(a_pix_data), 32'(pq[0].data));
                        chk("pix_x_idx", 32'(a_pix_x_idx), 32'(pq[0].ix));
                        chk("pix_z_idx", 32'(a_pix_z_idx), 32'(pq[0].iz));
                        chk("pix_last", 32'(a_pix_last), 32'(pq[0].last));
                        if (a_pix_ready) begin
                            done_exp = pq[0].last;
                            void'(pq.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start_a();
        @(posedge clk); #2;
        a_start = 1'b1;
        @(posedge clk); #2;
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int maxc, output bit got,
                               output logic [17:0] ld, output int lx, output int lz);
        got = 1'b0; ld = '0; lx = -1; lz = -1;
        for (int k = 0; k < maxc; k++) begin
            @(posedge clk); #2;
            if (a_pix_valid && a_pix_last) begin
                ld = a_pix_data; lx = int'(a_pix_x_idx); lz = int'(a_pix_z_idx);
            end
            if (a_frame_done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        logic [17:0] ld;
        int          lx, lz, n, k, bs0;
        logic [15:0] bx[4];

        reset = 1'b0;
        a_start = 0; a_abort = 0; a_pix_ready = 1'b1;
        b_start = 0; b_abort = 0; b_pix_ready = 1'b1;

        // Reset state
        #12;
        chk("rst busy", 32'(a_busy), 0);
        chk("rst state", 32'(a_debug_state), 0);
        chk("rst bf_x_f", 32'(a_bf_x_f), 10);
        chk("rst bf_z_f", 32'(a_bf_z_f), 0);
        chk("rst pix_valid", 32'(a_pix_valid), 0);
        chk("rst pix_data", 32'(a_pix_data), 0);
        chk("rst bf_start", 32'(a_bf_start), 0);
        chk("rst b bf_x_f", 32'(b_bf_x_f), 32'h0000FFFE);
        @(posedge clk); #2;
        reset = 1'b1;

        // Full frame, ready always high
        push_frame(2, 3, 10, 5, 0, 4);
        bs0 = bs_cnt;
        pulse_start_a();
        chk("bf_start one cycle after accept", 32'(a_bf_start), 1);
        wait_done_a(200, got, ld, lx, lz);
        if (!got) fail_now("frame 1 no frame_done");
        chk("f1 last data", 32'(ld), 248);
        chk("f1 last x_idx", 32'(lx), 1);
        chk("f1 last z_idx", 32'(lz), 2);
        chk("f1 bf_start count", 32'(bs_cnt - bs0), 6);
        chk("f1 pixels left", 32'(pq.size()), 0);
        @(posedge clk); #2;
        chk("f1 idle", 32'(a_busy), 0);

        // Backpressure on pixel 2
        push_frame(2, 3, 10, 5, 0, 4);
        a_pix_ready = 1'b0;
        pulse_start_a();
        k = 0;
        while (!a_pix_valid && k < 50) begin @(posedge clk); #2; k++; end
        if (!a_pix_valid) fail_now("bp pixel 1 never valid");
        a_pix_ready = 1'b1;
        @(posedge clk); #2;
        a_pix_ready = 1'b0;
        k = 0;
        while (!a_pix_valid && k < 50) begin @(posedge clk); #2; k++; end
        if (!a_pix_valid) fail_now("bp pixel 2 never valid");
        bs0 = bs_cnt;
        repeat (6) begin @(posedge clk); #2; end
        chk("bp held valid", 32'(a_pix_valid), 1);
        chk("bp held data", 32'(a_pix_data), 164);
        chk("bp held z_idx", 32'(a_pix_z_idx), 1);
        chk("bp no bf_start", 32'(bs_cnt - bs0), 0);
        a_pix_ready = 1'b1;
        wait_done_a(200, got, ld, lx, lz);
        if (!got) fail_now("frame 2 no frame_done");
        chk("bp pixels left", 32'(pq.size()), 0);

        // Timeout: core silent
        core_en = 1'b0;
        push_frame(2, 3, 10, 5, 0, 4);
        pulse_start_a();
        chk("to bf_start", 32'(a_bf_start), 1);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #2; n++;
            if (a_err_timeout) break;
        end
        chk("to cycles after bf_start", 32'(n), 9);
        chk("to busy", 32'(a_busy), 0);
        chk("to state", 32'(a_debug_state), 0);
        chk("to frame_done", 32'(a_frame_done), 0);
        @(posedge clk); #2;
        chk("to single pulse", 32'(a_err_timeout), 0);
        flush();
        core_en = 1'b1;

        // Abort in WAIT of pixel 3, then late bf_valid
        push_frame(2, 3, 10, 5, 0, 4);
        pulse_start_a();
        n = 0; k = 0;
        while (n < 3 && k < 100) begin
            if (a_bf_start) n++;
            if (n < 3) begin @(posedge clk); #2; k++; end
        end
        if (n < 3) fail_now("abort: pixel 3 never issued");
        @(posedge clk); #2;
        chk("ab in wait", 32'(a_debug_state), 2);
        a_abort = 1'b1;
        flush();
        @(posedge clk); #2;
        a_abort = 1'b0;
        a_late  = 1'b1;
        chk("ab state", 32'(a_debug_state), 0);
        chk("ab busy", 32'(a_busy), 0);
        chk("ab bf_start", 32'(a_bf_start), 0);
        repeat (4) begin
            @(posedge clk); #2;
            chk("ab late valid ignored", 32'(a_pix_valid), 0);
        end
        push_frame(2, 3, 10, 5, 0, 4);
        pulse_start_a();
        chk("ab restart x", 32'(a_bf_x_f), 10);
        chk("ab restart z", 32'(a_bf_z_f), 0);
        wait_done_a(200, got, ld, lx, lz);
        if (!got) fail_now("restart no frame_done");

        // Lateral wrap on instance B
        @(posedge clk); #2;
        b_start = 1'b1;
        @(posedge clk); #2;
        b_start = 1'b0;
        n = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_bf_start && n < 4) begin bx[n] = b_bf_x_f; n++; end
            if (b_frame_done) begin got = 1'b1; break; end
            @(posedge clk); #2;
        end
        if (!got) fail_now("wrap no frame_done");
        chk("wrap count", 32'(n), 4);
        chk("wrap x0", 32'(bx[0]), 32'h0000FFFE);
        chk("wrap x1", 32'(bx[1]), 32'h0000FFFF);
        chk("wrap x2", 32'(bx[2]), 32'h00000000);
        chk("wrap x3", 32'(bx[3]), 32'h00000001);

        // Async reset while holding in OUTPUT
        push_frame(2, 3, 10, 5, 0, 4);
        a_pix_ready = 1'b0;
        pulse_start_a();
        k = 0;
        while (!a_pix_valid && k < 50) begin @(posedge clk); #2; k++; end
        if (!a_pix_valid) fail_now("rst-mid pixel never valid");
        #1;
        reset = 1'b0;
        flush();
        #1;
        chk("rm pix_valid", 32'(a_pix_valid), 0);
        chk("rm busy", 32'(a_busy), 0);
        chk("rm state", 32'(a_debug_state), 0);
        chk("rm bf_x_f", 32'(a_bf_x_f), 10);
        @(posedge clk); #2;
        reset = 1'b1;
        a_pix_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #2;
            chk("rm no frame_done", 32'(a_frame_done), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf_scan_scheduler.md
Name: bf_scan_scheduler

Overview:
- Frame-level sequencer for the delay-and-sum beamformer core (top_bf).
- Walks a raster of focal points, outer loop over lateral lines (x), inner loop over depth points (z).
- For each point: drives x_f/z_f, pulses the core's start, waits for its valid result, then forwards the 18-bit beamformed sample on a valid/ready stream to the scan-conversion/frame-buffer stage.

Parameters:
- COORD_W, 16, width of focal coordinates x_f/z_f.
- OUT_W, 18, width of beamformed sample.
- NUM_X, 4, lateral lines per frame (>=1).
- NUM_Z, 256, depth points per line (>=1).
- X_START, 0, first lateral coordinate.
- X_STEP, 1, lateral coordinate increment.
- Z_START, 0, first depth coordinate.
- Z_STEP, 1, depth coordinate increment.
- TIMEOUT, 1023, max WAIT cycles before the frame is aborted with error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  frame request, sampled in IDLE only.
- abort  in  1  synchronous frame abort, any state.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel handshake.
- err_timeout  out  1  one-cycle pulse when WAIT exceeds TIMEOUT.
- bf_start  out  1  one-cycle start pulse to the beamformer core.
- bf_x_f  out  COORD_W  lateral focal coordinate to the core.
- bf_z_f  out  COORD_W  depth focal coordinate to the core.
- bf_valid  in  1  core result valid.
- bf_data  in  OUT_W  core beamformed output.
- pix_valid  out  1  output stream valid.
- pix_ready  in  1  output stream ready.
- pix_data  out  OUT_W  captured sample.
- pix_x_idx  out  clog2(NUM_X) (min 1)  line index of pix_data.
- pix_z_idx  out  clog2(NUM_Z) (min 1)  depth index of pix_data.
- pix_last  out  1  high with the final pixel of the frame.
- debug_state  out  2  current FSM state encoding.

Behaviour:
- Reset values (reset=0): state IDLE; busy, frame_done, err_timeout, bf_start, pix_valid, pix_last = 0; bf_x_f = X_START; bf_z_f = Z_START; pix_data, indices, timeout counter = 0.
- FSM encoding: IDLE=0, ISSUE=1, WAIT=2, OUTPUT=3.
- IDLE:
  - If start=1 and abort=0: clear indices, load bf_x_f=X_START and bf_z_f=Z_START, go to ISSUE.
  - start is level-sampled; held high, it restarts a new frame the cycle after returning to IDLE.
- ISSUE:
  - bf_start=1 for exactly this one cycle, then go to WAIT.
  - bf_start rises 1 cycle after start is accepted.
  - Coordinates are stable from ISSUE through OUTPUT.
- WAIT:
  - Timeout counter increments each cycle.
  - On bf_valid=1: capture bf_data into pix_data, tag with current indices, clear the counter, go to OUTPUT.
  - If the counter reaches TIMEOUT with no bf_valid: pulse err_timeout, go to IDLE, no frame_done.
  - bf_valid arriving in any other state is ignored.
- OUTPUT:
  - pix_valid=1; pix_data and indices hold until pix_ready=1.
  - pix_last=1 iff ix=NUM_X-1 and iz=NUM_Z-1.
  - On handshake, if not last: advance iz. If iz wraps at NUM_Z-1, reset iz to 0, reset z to Z_START, advance ix and x by X_STEP. Otherwise z += Z_STEP. Then go to ISSUE.
  - On handshake, if last: pulse frame_done in the next cycle, go to IDLE.
  - Backpressure is unbounded; no sample is dropped.
- Coordinate arithmetic: incremental adds, modulo 2^COORD_W, unsigned wrap; no saturation.
- abort=1 has priority over every transition:
  - Next state IDLE; pix_valid, bf_start, pix_last deassert next cycle.
  - No frame_done, no err_timeout.
  - A bf_valid arriving after the abort is ignored.
- Simultaneous events:
  - abort beats start.
  - In WAIT, bf_valid on the same cycle the counter hits TIMEOUT wins: capture, no error.
- Throughput: minimum 3 cycles per pixel (ISSUE, WAIT with 1-cycle core, OUTPUT with ready=1), plus core latency.
- Reset mid-frame: immediate return to reset values; the core is not notified beyond bf_start=0.

Test Plan:
- NUM_X=2, NUM_Z=3, X_START=10, X_STEP=5, Z_START=0, Z_STEP=4; core model with 2-cycle latency returning data = x*16+z; pix_ready=1 -> 6 pixels in order (x,z) = (10,0),(10,4),(10,8),(15,0),(15,4),(15,8). pix_last only on the 6th. frame_done one cycle after it. bf_start pulsed exactly 6 times.
- Same config with pix_ready low for 7 cycles on pixel 2 -> pix_valid, pix_data and indices held constant; no new bf_start until the handshake; all 6 pixels delivered intact.
- Core never asserts bf_valid, TIMEOUT=8 -> err_timeout pulse 9 cycles after bf_start (counter hits 8); busy drops; no frame_done; debug_state returns to 0.
- abort asserted in WAIT of pixel 3, with a late bf_valid 2 cycles later -> state IDLE next cycle; late bf_valid produces no pix_valid; a new start restarts at (10,0).
- X_START=16'hFFFE, X_STEP=1, NUM_X=4, NUM_Z=1 -> bf_x_f sequence FFFE, FFFF, 0000, 0001.
- reset driven to 0 in OUTPUT with pix_valid=1 -> asynchronously pix_valid=0, busy=0, debug_state=0, bf_x_f=X_START; no frame_done after release.
